ext_trig_ctrl: RTL and testbench

Sequencing controller for the shared external-trigger line between quabo boards. It synchronizes the local MAROC pixel trigger and the incoming pad trigger, and arbitrates between them when both arrive. When the line is driven high for a local trigger, it masks that board's own echo on the input, forwards remote triggers to the MAROC as stretched pulses, and enforces a holdoff. It sits between the MAROC trigger logic and the pad IOBUF: `ext_drive` feeds the buffer tristate (T = ~`ext_drive`, I = 1), and the buffer output returns on `ext_trig_pad`.

---
 rtl/ext_trig_pkg.sv | 20 ++
 rtl/ext_trig_ctrl_sync_rise.sv | 36 +++
 rtl/ext_trig_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_ext_trig_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_trig_pkg.sv
// Shared types and defaults for the external-trigger line controller.
package ext_trig_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        ECHO,
        RX,
        HOLDOFF
    } state_t;

    localparam int MODE_TX = 0;
    localparam int MODE_RX = 1;

    localparam int DEF_PW_WIDTH  = 8;
    localparam int DEF_HO_WIDTH  = 16;
    localparam int DEF_CNT_WIDTH = 32;
    localparam int DEF_ECHO_MAX  = 16;

endpackage

// File: rtl/ext_trig_ctrl_sync_rise.sv
// Two-flop synchronizer with a registered rising-edge output.
// Edges are held off until the pipeline holds real input samples, so a level already high at reset release is not an edge.
module sync_rise (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic       r_meta;
    logic       r_sync;
    logic       r_prev;
    logic       r_rise;
    logic [2:0] r_arm;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_arm  <= 3'b000;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_arm  <= {r_arm[1:0], 1'b1};
            r_rise <= r_sync & ~r_prev & r_arm[2];
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_rise;

endmodule

// File: rtl/ext_trig_ctrl.sv
// Arbitrates local/remote triggers on the shared quabo trigger line.
//   IDLE    | waiting for an enabled rising edge
//   DRIVE   | line driven high for the latched pulse length
//   ECHO    | line released, waiting for it to fall (own echo masked)
//   RX      | remote trigger forwarded to the MAROC
//   HOLDOFF | dead time before the next trigger is accepted
module ext_trig_ctrl
    import ext_trig_pkg::*;
#(
    parameter int PW_WIDTH  = DEF_PW_WIDTH,
    parameter int HO_WIDTH  = DEF_HO_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int ECHO_MAX  = DEF_ECHO_MAX
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_cfg_mode,
    input  logic [PW_WIDTH-1:0]  i_cfg_pulse_len,
    input  logic [HO_WIDTH-1:0]  i_cfg_holdoff,
    input  logic                 i_cnt_clr,
    input  logic                 i_err_clr,
    input  logic                 i_pixel_trig_async,
    input  logic                 i_ext_trig_pad,
    output logic                 o_ext_drive,
    output logic                 o_ext_trig_out,
    output logic                 o_busy,
    output logic                 o_stuck_err,
    output logic [CNT_WIDTH-1:0] o_cnt_local,
    output logic [CNT_WIDTH-1:0] o_cnt_remote,
    output logic [CNT_WIDTH-1:0] o_cnt_dropped
);

    localparam int EW   = $clog2(ECHO_MAX + 1);
    localparam int TW_A = (PW_WIDTH > HO_WIDTH) ? PW_WIDTH : HO_WIDTH;
    localparam int TW   = (TW_A > EW) ? TW_A : EW;
    localparam logic [TW-1:0] ECHO_LOAD = TW'(ECHO_MAX - 1);

    logic w_loc_rise, w_rem_rise, w_pad_lvl, w_loc_lvl_unused;
    logic w_loc_en, w_rem_en;

    sync_rise u_sync_loc (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_pixel_trig_async),
        .o_level (w_loc_lvl_unused),
        .o_rise  (w_loc_rise)
    );

    sync_rise u_sync_rem (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_ext_trig_pad),
        .o_level (w_pad_lvl),
        .o_rise  (w_rem_rise)
    );

    state_t                r_state, w_state_nxt, w_exit_state;
    logic [TW-1:0]         r_tmr, w_tmr_nxt, w_pw_m1, w_ho_m1;
    logic [HO_WIDTH-1:0]   r_ho, w_ho_nxt;
    logic                  r_drive, r_trig_out, r_busy, r_stuck;
    logic                  w_inc_loc, w_inc_rem, w_stuck_set;
    logic [1:0]            w_drop;
    logic [CNT_WIDTH-1:0]  r_cnt_loc, r_cnt_rem, r_cnt_drop;

    assign w_loc_en     = w_loc_rise & i_cfg_mode[MODE_TX];
    assign w_rem_en     = w_rem_rise & i_cfg_mode[MODE_RX];
    assign w_pw_m1      = (i_cfg_pulse_len == '0) ? '0 : TW'(i_cfg_pulse_len) - TW'(1);
    assign w_ho_m1      = TW'(r_ho) - TW'(1);
    assign w_exit_state = (r_ho == '0) ? IDLE : HOLDOFF;

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_ho_nxt    = r_ho;
        w_inc_loc   = 1'b0;
        w_inc_rem   = 1'b0;
        w_stuck_set = 1'b0;
        w_drop      = 2'd0;
        case (r_state)
            IDLE: begin
                if (w_loc_en) begin
                    w_state_nxt = DRIVE;
                    w_tmr_nxt   = w_pw_m1;
                    w_ho_nxt    = i_cfg_holdoff;
                    w_inc_loc   = 1'b1;
                end else if (w_rem_en) begin
                    w_state_nxt = RX;
                    w_tmr_nxt   = w_pw_m1;
                    w_ho_nxt    = i_cfg_holdoff;
                    w_inc_rem   = 1'b1;
                end
            end
            DRIVE: begin
                w_drop = {1'b0, w_loc_en} + {1'b0, w_rem_en};
                if (r_tmr == '0) begin
                    w_state_nxt = ECHO;
                    w_tmr_nxt   = ECHO_LOAD;
                end else begin
                    w_tmr_nxt = r_tmr - TW'(1);
                end
            end
            ECHO: begin
                // Remote edges here are our own line activity.
                w_drop = {1'b0, w_loc_en};
                if (!w_pad_lvl || r_tmr == '0) begin
                    w_stuck_set = w_pad_lvl;
                    w_state_nxt = w_exit_state;
                    w_tmr_nxt   = w_ho_m1;
                end else begin
                    w_tmr_nxt = r_tmr - TW'(1);
                end
            end
            RX: begin
                w_drop = {1'b0, w_loc_en} + {1'b0, w_rem_en};
                if (r_tmr == '0) begin
                    w_state_nxt = w_exit_state;
                    w_tmr_nxt   = w_ho_m1;
                end else begin
                    w_tmr_nxt = r_tmr - TW'(1);
                end
            end
            HOLDOFF: begin
                w_drop = {1'b0, w_loc_en} + {1'b0, w_rem_en};
                if (r_tmr == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_tmr_nxt = r_tmr - TW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_tmr      <= '0;
            r_ho       <= '0;
            r_drive    <= 1'b0;
            r_trig_out <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tmr      <= w_tmr_nxt;
            r_ho       <= w_ho_nxt;
            r_drive    <= (w_state_nxt == DRIVE);
            r_trig_out <= (w_state_nxt == RX);
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] v,
                                                      input logic [1:0] inc);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, v} + {{(CNT_WIDTH-1){1'b0}}, inc};
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt_loc  <= '0;
            r_cnt_rem  <= '0;
            r_cnt_drop <= '0;
            r_stuck    <= 1'b0;
        end else begin
            if (i_cnt_clr) begin
                r_cnt_loc  <= '0;
                r_cnt_rem  <= '0;
                r_cnt_drop <= '0;
            end else begin
                r_cnt_loc  <= sat_add(r_cnt_loc, {1'b0, w_inc_loc});
                r_cnt_rem  <= sat_add(r_cnt_rem, {1'b0, w_inc_rem});
                r_cnt_drop <= sat_add(r_cnt_drop, w_drop);
            end
            if (w_stuck_set)
                r_stuck <= 1'b1;
            else if (i_err_clr)
                r_stuck <= 1'b0;
        end
    end

    assign o_ext_drive    = r_drive;
    assign o_ext_trig_out = r_trig_out;
    assign o_busy         = r_busy;
    assign o_stuck_err    = r_stuck;
    assign o_cnt_local    = r_cnt_loc;
    assign o_cnt_remote   = r_cnt_rem;
    assign o_cnt_dropped  = r_cnt_drop;

endmodule

// File: tb/tb_ext_trig_ctrl.sv
// Directed bench for ext_trig_ctrl: vector table plus multi-cycle corner sequences.
module tb_ext_trig_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic [7:0]    plen;
    logic [15:0]   hold;
    logic          cnt_clr, err_clr, pix, pad_man, mirror, drive_d;
    logic          pad;
    logic          drv, tout, busy, stuck;
    logic [CW-1:0] c_loc, c_rem, c_drop;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(negedge clk) drive_d <= drv;
    assign pad = (mirror & drive_d) | pad_man;

    ext_trig_ctrl #(.PW_WIDTH(8), .HO_WIDTH(16), .CNT_WIDTH(CW), .ECHO_MAX(16)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_cfg_mode         (mode),
        .i_cfg_pulse_len    (plen),
        .i_cfg_holdoff      (hold),
        .i_cnt_clr          (cnt_clr),
        .i_err_clr          (err_clr),
        .i_pixel_trig_async (pix),
        .i_ext_trig_pad     (pad),
        .o_ext_drive        (drv),
        .o_ext_trig_out     (tout),
        .o_busy             (busy),
        .o_stuck_err        (stuck),
        .o_cnt_local        (c_loc),
        .o_cnt_remote       (c_rem),
        .o_cnt_dropped      (c_drop)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  len;
        logic [15:0] ho;
        bit          loc;
        bit          rem;
        int          rem_w;
        int          exp_drv;
        int          exp_out;
        int          exp_lat;
        int          exp_loc;
        int          exp_rem;
        int          exp_drop;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        chk(name, int'(busy), 0);
        repeat (6) tick();
    endtask

    task automatic clear_counts();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        repeat (2) tick();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int nd = 0, no = 0, first = -1;
        mode = v.mode; plen = v.len; hold = v.ho;
        mirror = 1'b1;
        clear_counts();
        for (int i = 0; i < 60; i++) begin
            tick();
            if (drv) nd++;
            if (tout) no++;
            if ((drv || tout) && first < 0) first = i;
            if (i == 2) pix = 1'b0;
            if (i == v.rem_w) pad_man = 1'b0;
            if (i == 0) begin
                pix = v.loc;
                pad_man = v.rem;
            end
        end
        chk($sformatf("v%0d_drive_cycles", idx), nd, v.exp_drv);
        chk($sformatf("v%0d_out_cycles", idx), no, v.exp_out);
        if (v.exp_lat >= 0) chk($sformatf("v%0d_latency", idx), first, v.exp_lat);
        chk($sformatf("v%0d_cnt_local", idx), int'(c_loc), v.exp_loc);
        chk($sformatf("v%0d_cnt_remote", idx), int'(c_rem), v.exp_rem);
        chk($sformatf("v%0d_cnt_dropped", idx), int'(c_drop), v.exp_drop);
        chk($sformatf("v%0d_stuck", idx), int'(stuck), 0);
        wait_idle($sformatf("v%0d_idle", idx));
    endtask

    task automatic run_drop(input bit with_rem, input int exp);
        mode = 2'd3; plen = 8'd2; hold = 16'd10; mirror = 1'b1;
        clear_counts();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 2 || i == 14) begin
                pix = 1'b0;
                pad_man = 1'b0;
            end
            if (i == 0) pix = 1'b1;
            if (i == 12) begin
                pix = 1'b1;
                pad_man = with_rem;
            end
        end
        chk($sformatf("holdoff_drop%0d_local", exp), int'(c_loc), 1);
        chk($sformatf("holdoff_drop%0d_dropped", exp), int'(c_drop), exp);
        wait_idle("holdoff_drop_idle");
    endtask

    initial begin
        rst = 1'b1; mode = 2'd0; plen = 8'd0; hold = 16'd0;
        cnt_clr = 1'b0; err_clr = 1'b0; pix = 1'b0; pad_man = 1'b0; mirror = 1'b1;
        repeat (3) tick();
        chk("rst_drive", int'(drv), 0);
        chk("rst_out", int'(tout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_stuck", int'(stuck), 0);
        chk("rst_counters", int'(c_loc) + int'(c_rem) + int'(c_drop), 0);
        @(negedge clk) rst = 1'b0;
        repeat (6) tick();

        //              mode  len    ho     loc   rem   rw  drv out lat loc rem drp
        vecs[0] = '{2'd3, 8'd4, 16'd10, 1'b1, 1'b0, 20, 4, 0,  4, 1, 0, 1};
        vecs[1] = '{2'd2, 8'd0, 16'd5,  1'b0, 1'b1, 20, 0, 1,  4, 0, 1, 0};
        vecs[2] = '{2'd1, 8'd0, 16'd5,  1'b0, 1'b1, 20, 0, 0, -1, 0, 0, 0};
        vecs[3] = '{2'd3, 8'd3, 16'd0,  1'b0, 1'b1, 5,  0, 3,  4, 0, 1, 0};
        vecs[4] = '{2'd1, 8'd2, 16'd3,  1'b1, 1'b0, 20, 2, 0,  4, 1, 0, 0};
        vecs[5] = '{2'd2, 8'd2, 16'd3,  1'b1, 1'b0, 20, 0, 0, -1, 0, 0, 0};
        vecs[6] = '{2'd0, 8'd2, 16'd3,  1'b1, 1'b1, 5,  0, 0, -1, 0, 0, 0};
        vecs[7] = '{2'd3, 8'd2, 16'd4,  1'b1, 1'b1, 6,  2, 0,  4, 1, 0, 0};
        for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

        run_drop(1'b0, 1);
        run_drop(1'b1, 2);

        // Line held high after our own drive.
        mode = 2'd1; plen = 8'd2; hold = 16'd4; mirror = 1'b0;
        clear_counts();
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 21) chk("stuck_before", int'(stuck), 0);
            if (i == 22) chk("stuck_set", int'(stuck), 1);
            if (i == 25) chk("stuck_holdoff_busy", int'(busy), 1);
            if (i == 26) chk("stuck_idle", int'(busy), 0);
            if (i == 2) begin
                pix = 1'b0;
                pad_man = 1'b1;
            end
            if (i == 0) pix = 1'b1;
        end
        chk("stuck_cnt_local", int'(c_loc), 1);
        pad_man = 1'b0;
        repeat (5) tick();
        chk("stuck_sticky", int'(stuck), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("stuck_cleared", int'(stuck), 0);

        // Reset during DRIVE, then release with the line already high.
        mode = 2'd1; plen = 8'd6; hold = 16'd4; mirror = 1'b0;
        clear_counts();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 2) pix = 1'b0;
            if (i == 0) pix = 1'b1;
        end
        chk("rstmid_drive_before", int'(drv), 1);
        chk("rstmid_local_before", int'(c_loc), 1);
        rst = 1'b1;
        #1;
        chk("rstmid_drive_async", int'(drv), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_counters", int'(c_loc) + int'(c_rem) + int'(c_drop), 0);
        pad_man = 1'b1; mode = 2'd3;
        repeat (2) tick();
        @(negedge clk) rst = 1'b0;
        begin
            int act = 0;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (busy || tout || drv) act++;
            end
            chk("rstrel_no_activity", act, 0);
            chk("rstrel_cnt_remote", int'(c_rem), 0);
        end
        pad_man = 1'b0;
        repeat (6) tick();

        // Saturate dropped during a long holdoff, then clear on a drop edge.
        mode = 2'd3; plen = 8'd1; hold = 16'd200; mirror = 1'b0;
        clear_counts();
        for (int i = 0; i < 110; i++) begin
            tick();
            if (i == 30) chk("sat_partial", int'(c_drop), 5);
            if (i == 95) chk("sat_hold", int'(c_drop), 15);
            if (i == 104) begin
                chk("clr_vs_inc_dropped", int'(c_drop), 0);
                chk("clr_remote", int'(c_rem), 0);
                cnt_clr = 1'b0;
            end
            if (i == 108) chk("clr_stays", int'(c_drop), 0);
            if (i == 3) pad_man = 1'b0;
            if (i == 0) pad_man = 1'b1;
            if (i >= 10 && i < 90) pix = (((i - 10) % 4) < 2);
            if (i == 100) pix = 1'b1;
            if (i == 102) pix = 1'b0;
            if (i == 103) cnt_clr = 1'b1;
        end
        wait_idle("sat_idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
